// File: rtl/orion_types.sv
// Shared pipeline types for the orion core: memory-op encoding, stage bundles,
// and the store byte-lane helper used by the memory stage.
package orion_types;

  localparam int XLEN  = 32;
  localparam int ADDRW = 32;
  localparam int MASKW = 4;

  typedef enum logic [3:0] {
    MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
  } mem_op_e;

  typedef enum logic {IDLE, WAIT_RSP} mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;
  } dbg_core_t;

  typedef struct packed {
    dbg_core_t        core;
    logic [ADDRW-1:0] mem_addr;
    logic [MASKW-1:0] mem_rmask;
    logic [MASKW-1:0] mem_wmask;
    logic [XLEN-1:0]  mem_rdata;
    logic [XLEN-1:0]  mem_wdata;
  } debug_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      rd_s;
    logic            rd_we;
    mem_op_e         mem_op;
    logic [XLEN-1:0] st_data;
    dbg_core_t       debug;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic            rd_we;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] rd_v;
    debug_t          debug;
  } mem_wb_t;

  typedef struct packed {
    logic [MASKW-1:0] wmask;
    logic [XLEN-1:0]  wdata;
  } store_lanes_t;

  function automatic logic is_load_op(mem_op_e op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store_op(mem_op_e op);
    return op inside {SB, SH, SW};
  endfunction

  // Non-store ops return all zeros so callers can use the result unconditionally.
  function automatic store_lanes_t mem_store_lanes(mem_op_e op, logic [1:0] addr_lo,
                                                   logic [XLEN-1:0] st_data);
    store_lanes_t r;
    r = '0;
    case (op)
      SB: begin
        r.wmask = MASKW'(1) << addr_lo;
        r.wdata = {4{st_data[7:0]}};
      end
      SH: begin
        r.wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
        r.wdata = {2{st_data[15:0]}};
      end
      SW: begin
        r.wmask = 4'b1111;
        r.wdata = st_data;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data lane selection and sign/zero extension; purely combinational.
module mem_load_align
  import orion_types::*;
(
  input  mem_op_e          mem_op_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  value_o,
  output logic [MASKW-1:0] rmask_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[8*addr_lo_i +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    value_o = '0;
    rmask_o = '0;
    case (mem_op_i)
      LB, LBU: begin
        value_o = (mem_op_i == LB) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
        rmask_o = MASKW'(1) << addr_lo_i;
      end
      LH, LHU: begin
        value_o = (mem_op_i == LH) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
        rmask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      LW: begin
        value_o = rdata_i;
        rmask_o = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: issues data-memory requests, stalls upstream
// while a load is outstanding, and registers the writeback bundle.
module mem_stage
  import orion_types::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  ex_mem_t          ex_mem_i,
  output logic             stall_o,
  output logic             dmem_req_valid_o,
  input  logic             dmem_req_ready_i,
  output logic [ADDRW-1:0] dmem_addr_o,
  output logic             dmem_we_o,
  output logic [MASKW-1:0] dmem_wmask_o,
  output logic [XLEN-1:0]  dmem_wdata_o,
  input  logic             dmem_rsp_valid_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output mem_wb_t          mem_wb_o
);

  mem_state_e   state_q, state_d;
  mem_wb_t      mem_wb_q, mem_wb_d;
  logic         is_load, is_store;
  store_lanes_t lanes;
  logic [XLEN-1:0]  load_val;
  logic [MASKW-1:0] load_rmask;
  debug_t       dbg;

  // Decode is gated by valid so a stale memory op can never issue a request.
  assign is_load  = ex_mem_i.valid && is_load_op(ex_mem_i.mem_op);
  assign is_store = ex_mem_i.valid && is_store_op(ex_mem_i.mem_op);
  assign lanes    = mem_store_lanes(ex_mem_i.mem_op, ex_mem_i.alu_res[1:0], ex_mem_i.st_data);

  mem_load_align u_align (
    .mem_op_i  (ex_mem_i.mem_op),
    .addr_lo_i (ex_mem_i.alu_res[1:0]),
    .rdata_i   (dmem_rdata_i),
    .value_o   (load_val),
    .rmask_o   (load_rmask)
  );

  always_comb begin
    dbg           = '0;
    dbg.core      = ex_mem_i.debug;
    dbg.mem_addr  = (is_load || is_store) ? ex_mem_i.alu_res : '0;
    dbg.mem_rmask = is_load ? load_rmask : '0;
    dbg.mem_wmask = lanes.wmask;
    dbg.mem_rdata = is_load ? dmem_rdata_i : '0;
    dbg.mem_wdata = lanes.wdata;
  end

  always_comb begin
    state_d          = state_q;
    mem_wb_d         = '0;
    stall_o          = 1'b0;
    dmem_req_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          dmem_req_valid_o = 1'b1;
          if (!dmem_req_ready_i) begin
            stall_o = 1'b1;
          end else if (is_store) begin
            mem_wb_d = '{valid: 1'b1, rd_we: 1'b0, rd_s: ex_mem_i.rd_s, rd_v: '0, debug: dbg};
          end else begin
            stall_o = 1'b1;
            state_d = WAIT_RSP;
          end
        end else if (ex_mem_i.valid) begin
          mem_wb_d = '{valid: 1'b1, rd_we: ex_mem_i.rd_we, rd_s: ex_mem_i.rd_s,
                       rd_v: ex_mem_i.alu_res, debug: dbg};
        end
      end
      WAIT_RSP: begin
        // Upstream is stalled, so ex_mem_i still describes the outstanding load.
        if (dmem_rsp_valid_i) begin
          mem_wb_d = '{valid: 1'b1, rd_we: ex_mem_i.rd_we, rd_s: ex_mem_i.rd_s,
                       rd_v: load_val, debug: dbg};
          state_d  = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_addr_o  = {ex_mem_i.alu_res[ADDRW-1:2], 2'b00};
  assign dmem_we_o    = dmem_req_valid_o && is_store;
  assign dmem_wmask_o = dmem_req_valid_o ? lanes.wmask : '0;
  assign dmem_wdata_o = lanes.wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign mem_wb_o = mem_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, stores, loads,
// request back-pressure, reset mid-transaction and SW/LW ordering.
module tb_mem_stage;
  import orion_types::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  ex_mem_t          ex_mem_i;
  logic             stall_o;
  logic             dmem_req_valid_o;
  logic             dmem_req_ready_i;
  logic [ADDRW-1:0] dmem_addr_o;
  logic             dmem_we_o;
  logic [MASKW-1:0] dmem_wmask_o;
  logic [XLEN-1:0]  dmem_wdata_o;
  logic             dmem_rsp_valid_i;
  logic [XLEN-1:0]  dmem_rdata_i;
  mem_wb_t          mem_wb_o;

  int vectors = 0;
  int errors  = 0;
  int stall_cycles;

  mem_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ex_mem_i         (ex_mem_i),
    .stall_o          (stall_o),
    .dmem_req_valid_o (dmem_req_valid_o),
    .dmem_req_ready_i (dmem_req_ready_i),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_wmask_o     (dmem_wmask_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_rsp_valid_i (dmem_rsp_valid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .mem_wb_o         (mem_wb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic valid, input mem_op_e op, input logic [31:0] addr,
                       input logic [31:0] st, input logic [4:0] rd, input logic we);
    ex_mem_i            = '0;
    ex_mem_i.valid      = valid;
    ex_mem_i.mem_op     = op;
    ex_mem_i.alu_res    = addr;
    ex_mem_i.st_data    = st;
    ex_mem_i.rd_s       = rd;
    ex_mem_i.rd_we      = we;
    ex_mem_i.debug.pc   = 32'h0000_0100 + addr;
    ex_mem_i.debug.instr = 32'h0000_0013;
  endtask

  initial begin
    rst_i            = 1'b0;
    ex_mem_i         = '0;
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rdata_i     = '0;
    step();
    step();
    check("reset_wb_valid", 32'(mem_wb_o.valid), 32'd0);
    check("reset_wb_all",   32'(mem_wb_o.rd_v), 32'd0);
    check("reset_stall",    32'(stall_o), 32'd0);
    rst_i = 1'b1;

    // ALU pass-through
    drive(1'b1, MEM_NONE, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    check("add_stall", 32'(stall_o), 32'd0);
    check("add_req",   32'(dmem_req_valid_o), 32'd0);
    step();
    check("add_valid", 32'(mem_wb_o.valid), 32'd1);
    check("add_rd_s",  32'(mem_wb_o.rd_s), 32'd5);
    check("add_rd_v",  mem_wb_o.rd_v, 32'h1234);
    check("add_rd_we", 32'(mem_wb_o.rd_we), 32'd1);
    check("add_pc",    mem_wb_o.debug.core.pc, 32'h0000_1334);

    // SB to the top byte lane
    drive(1'b1, SB, 32'h1003, 32'h0000_00AB, 5'd0, 1'b0);
    dmem_req_ready_i = 1'b1;
    #1;
    check("sb_req",   32'(dmem_req_valid_o), 32'd1);
    check("sb_we",    32'(dmem_we_o), 32'd1);
    check("sb_addr",  dmem_addr_o, 32'h1000);
    check("sb_wmask", 32'(dmem_wmask_o), 32'h8);
    check("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    check("sb_stall", 32'(stall_o), 32'd0);
    step();
    check("sb_valid",     32'(mem_wb_o.valid), 32'd1);
    check("sb_rd_we",     32'(mem_wb_o.rd_we), 32'd0);
    check("sb_dbg_addr",  mem_wb_o.debug.mem_addr, 32'h1003);
    check("sb_dbg_wmask", 32'(mem_wb_o.debug.mem_wmask), 32'h8);
    check("sb_dbg_rmask", 32'(mem_wb_o.debug.mem_rmask), 32'h0);

    // SH to the upper half
    drive(1'b1, SH, 32'h6002, 32'h5555_1234, 5'd0, 1'b0);
    #1;
    check("sh_wmask", 32'(dmem_wmask_o), 32'hC);
    check("sh_wdata", dmem_wdata_o, 32'h1234_1234);
    step();

    // LH from the upper half, response three cycles after issue
    drive(1'b1, LH, 32'h2002, 32'h0, 5'd7, 1'b1);
    stall_cycles = 0;
    #1;
    check("lh_req",   32'(dmem_req_valid_o), 32'd1);
    check("lh_we",    32'(dmem_we_o), 32'd0);
    check("lh_wmask", 32'(dmem_wmask_o), 32'h0);
    if (stall_o) stall_cycles++;
    step();
    check("lh_bubble0", 32'(mem_wb_o.valid), 32'd0);
    dmem_req_ready_i = 1'b0;
    #1;
    check("lh_wait_req", 32'(dmem_req_valid_o), 32'd0);
    if (stall_o) stall_cycles++;
    step();
    check("lh_bubble1", 32'(mem_wb_o.valid), 32'd0);
    if (stall_o) stall_cycles++;
    step();
    check("lh_bubble2", 32'(mem_wb_o.valid), 32'd0);
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'h8001_7FFF;
    #1;
    check("lh_rsp_stall", 32'(stall_o), 32'd0);
    check("lh_stall_cycles", 32'(stall_cycles), 32'd3);
    step();
    check("lh_valid",     32'(mem_wb_o.valid), 32'd1);
    check("lh_rd_v",      mem_wb_o.rd_v, 32'hFFFF_8001);
    check("lh_rd_s",      32'(mem_wb_o.rd_s), 32'd7);
    check("lh_dbg_rmask", 32'(mem_wb_o.debug.mem_rmask), 32'hC);
    check("lh_dbg_rdata", mem_wb_o.debug.mem_rdata, 32'h8001_7FFF);
    dmem_rsp_valid_i = 1'b0;

    // LBU with request back-pressure for three cycles
    drive(1'b1, LBU, 32'h3001, 32'h0, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lbu_hold_req",   32'(dmem_req_valid_o), 32'd1);
      check("lbu_hold_addr",  dmem_addr_o, 32'h3000);
      check("lbu_hold_stall", 32'(stall_o), 32'd1);
      step();
      check("lbu_hold_bubble", 32'(mem_wb_o.valid), 32'd0);
    end
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'h0000_F000;
    step();
    check("lbu_rd_v",  mem_wb_o.rd_v, 32'h0000_00F0);
    check("lbu_rmask", 32'(mem_wb_o.debug.mem_rmask), 32'h2);
    dmem_rsp_valid_i = 1'b0;

    // LB sign extension from lane 3
    drive(1'b1, LB, 32'h7003, 32'h0, 5'd4, 1'b1);
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'h8000_0000;
    step();
    check("lb_rd_v", mem_wb_o.rd_v, 32'hFFFF_FF80);
    dmem_rsp_valid_i = 1'b0;

    // Invalid memory op must not issue
    drive(1'b0, SW, 32'h8000, 32'h1, 5'd1, 1'b0);
    #1;
    check("inv_req", 32'(dmem_req_valid_o), 32'd0);
    step();
    check("inv_valid", 32'(mem_wb_o.valid), 32'd0);

    // Reset while waiting for a load response
    drive(1'b1, LW, 32'h4000, 32'h0, 5'd6, 1'b1);
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    #1;
    check("rst_pre_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    rst_i = 1'b1;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_valid", 32'(mem_wb_o.valid), 32'd0);
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'hCAFE_F00D;
    step();
    check("rst_late_rsp", 32'(mem_wb_o.valid), 32'd0);
    dmem_rsp_valid_i = 1'b0;

    // Back-to-back SW then LW to the same address
    drive(1'b1, SW, 32'h5004, 32'hDEAD_BEEF, 5'd0, 1'b0);
    dmem_req_ready_i = 1'b1;
    #1;
    check("sw_wmask", 32'(dmem_wmask_o), 32'hF);
    check("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
    check("sw_stall", 32'(stall_o), 32'd0);
    step();
    check("sw_valid",     32'(mem_wb_o.valid), 32'd1);
    check("sw_rd_we",     32'(mem_wb_o.rd_we), 32'd0);
    check("sw_dbg_wdata", mem_wb_o.debug.mem_wdata, 32'hDEAD_BEEF);
    drive(1'b1, LW, 32'h5004, 32'h0, 5'd9, 1'b1);
    #1;
    check("lw_req",  32'(dmem_req_valid_o), 32'd1);
    check("lw_addr", dmem_addr_o, 32'h5004);
    step();
    check("lw_bubble", 32'(mem_wb_o.valid), 32'd0);
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'hDEAD_BEEF;
    step();
    check("lw_valid", 32'(mem_wb_o.valid), 32'd1);
    check("lw_rd_s",  32'(mem_wb_o.rd_s), 32'd9);
    check("lw_rd_v",  mem_wb_o.rd_v, 32'hDEAD_BEEF);
    dmem_rsp_valid_i = 1'b0;
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
